bcd_conversion_scheduler: RTL and testbench

- Sequential binary-to-BCD converter and update scheduler that drives the four digit inputs (ones, tens, hundreds, thousands) of the 4-digit multiplexed seven-segment display top level.
- Accepts one binary value per valid/ready handshake and converts it with a multi-cycle shift-add-3 (double-dabble) engine.
- Publishes all four digits atomically, so the scanning display never shows a partially converted value.

---
 rtl/bcd_conversion_scheduler.sv | 117 +++++++++++
 tb/tb_bcd_conversion_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conversion_scheduler.sv
// Sequential binary-to-BCD converter for a 4-digit display.
// Double-dabble engine with atomic publication of all four digits.
module bcd_conversion_scheduler #(
    parameter int BIN_W   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [BIN_W-1:0] in_bin,
    output logic             in_ready,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic [3:0]       hundreds,
    output logic [3:0]       thousands,
    output logic             out_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int CNT_W = $clog2(BIN_W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [BIN_W-1:0] MAX_B    = BIN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W - 1);

    logic [1:0]       r_state;
    logic [BIN_W-1:0] r_sh;
    logic [15:0]      r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic [3:0]       r_ones;
    logic [3:0]       r_tens;
    logic [3:0]       r_hund;
    logic [3:0]       r_thou;
    logic             r_ovf;
    logic             r_ovalid;

    logic [15:0]      w_adj;
    logic             w_accept;

    // Nibble correction happens before the shift; nibbles never carry.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    assign w_accept = in_valid && (r_state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_sh     <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_sat    <= 1'b0;
            r_ones   <= '0;
            r_tens   <= '0;
            r_hund   <= '0;
            r_thou   <= '0;
            r_ovf    <= 1'b0;
            r_ovalid <= 1'b0;
        end else begin
            r_ovalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (in_bin > MAX_B) begin
                            r_sh  <= MAX_B;
                            r_sat <= 1'b1;
                        end else begin
                            r_sh  <= in_bin;
                            r_sat <= 1'b0;
                        end
                        r_bcd   <= '0;
                        r_cnt   <= CNT_INIT;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= {w_adj[14:0], r_sh[BIN_W-1]};
                    r_sh  <= {r_sh[BIN_W-2:0], 1'b0};
                    if (r_cnt == '0)
                        r_state <= S_DONE;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                S_DONE: begin
                    r_ones   <= r_bcd[3:0];
                    r_tens   <= r_bcd[7:4];
                    r_hund   <= r_bcd[11:8];
                    r_thou   <= r_bcd[15:12];
                    r_ovf    <= r_sat;
                    r_ovalid <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign ones      = r_ones;
    assign tens      = r_tens;
    assign hundreds  = r_hund;
    assign thousands = r_thou;
    assign overflow  = r_ovf;
    assign out_valid = r_ovalid;

endmodule

// File: tb/tb_bcd_conversion_scheduler.sv
// Randomized self-checking bench for bcd_conversion_scheduler.
// Reference: decimal digits computed by division on a saturated value.
module tb_bcd_conversion_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [13:0] in_bin = '0;
    logic        in_ready;
    logic [3:0]  ones, tens, hundreds, thousands;
    logic        out_valid, overflow, busy;

    int errors = 0;
    int checks = 0;
    int accepts = 0;
    int pulses = 0;

    logic [15:0] m_disp = '0;
    logic        m_ovf = 1'b0;

    bcd_conversion_scheduler #(.BIN_W(14), .MAX_VAL(9999)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bin(in_bin),
        .in_ready(in_ready), .ones(ones), .tens(tens),
        .hundreds(hundreds), .thousands(thousands),
        .out_valid(out_valid), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_valid && in_ready) accepts++;
        if (out_valid) pulses++;
    end

    function automatic logic [16:0] ref_disp(input int v);
        int s;
        logic [15:0] d;
        s = (v > 9999) ? 9999 : v;
        d[15:12] = 4'((s / 1000) % 10);
        d[11:8]  = 4'((s / 100) % 10);
        d[7:4]   = 4'((s / 10) % 10);
        d[3:0]   = 4'(s % 10);
        return {(v > 9999), d};
    endfunction

    function automatic logic [19:0] obs();
        return {in_ready, busy, out_valid, overflow,
                thousands, hundreds, tens, ones};
    endfunction

    // Full conversion with a per-cycle check of handshake and output timing.
    task automatic do_conv(input int v, input string name);
        int w;
        logic [16:0] r;
        logic [19:0] e;
        logic [19:0] o;
        r = ref_disp(v);
        @(negedge clk);
        in_valid = 1'b1;
        in_bin = 14'(v);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 50) begin
            errors++;
            $display("FAIL %s accept_timeout in_ready=%b want 1", name, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bin = 14'($urandom);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (k < 15)
                e = {1'b0, 1'b1, 1'b0, m_ovf, m_disp};
            else if (k == 15)
                e = {1'b1, 1'b0, 1'b1, r};
            else
                e = {1'b1, 1'b0, 1'b0, r};
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s v=%0d edge%0d got=%h want=%h",
                         name, v, k, o, e);
            end
        end
        m_ovf = r[16];
        m_disp = r[15:0];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs() !== 20'h80000) begin
                errors++;
                $display("FAIL reset_idle cyc%0d got=%h want=80000", k, obs());
            end
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_no_pulse got=%0d want 0", pulses);
        end
    endtask

    task automatic test_basic();
        do_conv(1234, "basic_1234");
    endtask

    task automatic test_boundaries();
        do_conv(9999, "max_val");
        do_conv(0, "zero");
        do_conv(12000, "sat_12000");
        do_conv(16383, "sat_16383");
        do_conv(5, "after_sat_5");
        do_conv(10000, "sat_10000");
        do_conv(9998, "near_max");
    endtask

    task automatic test_back_to_back();
        int a0;
        int w;
        logic [19:0] o;
        a0 = accepts;
        @(negedge clk);
        in_valid = 1'b1;
        in_bin = 14'd42;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk);
            #1;
            o = obs();
            if (k == 15) begin
                in_bin = 14'd7;
                checks++;
                if (o !== 20'hA0042) begin
                    errors++;
                    $display("FAIL b2b_first edge15 got=%h want=a0042", o);
                end
            end else if (k == 16) begin
                checks++;
                if (o[19] !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_accept edge16 in_ready=%b want 0", o[19]);
                end
            end else if (k == 31) begin
                in_valid = 1'b0;
                checks++;
                if (o !== 20'hA0007) begin
                    errors++;
                    $display("FAIL b2b_second edge31 got=%h want=a0007", o);
                end
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (accepts - a0 !== 2) begin
            errors++;
            $display("FAIL b2b_accepts got=%0d want 2", accepts - a0);
        end
        m_disp = 16'h0007;
        m_ovf = 1'b0;
    endtask

    task automatic test_reset_mid();
        int p0;
        @(negedge clk);
        in_valid = 1'b1;
        in_bin = 14'd5678;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        p0 = pulses;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 20'h80000) begin
            errors++;
            $display("FAIL rst_mid_async got=%h want=80000", obs());
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (pulses !== p0 || obs() !== 20'h80000) begin
            errors++;
            $display("FAIL rst_mid_quiet pulses=%0d want %0d state=%h want=80000",
                     pulses - p0, 0, obs());
        end
        m_disp = '0;
        m_ovf = 1'b0;
        do_conv(321, "after_rst_321");
    endtask

    task automatic test_random();
        int v;
        for (int i = 0; i < 25; i++) begin
            if (i % 4 == 0)
                v = int'($urandom_range(10000, 16383));
            else
                v = int'($urandom_range(0, 9999));
            do_conv(v, "random");
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
